bus_msg_transmitter: RTL
========================

BUS_MSG_TRANSMITTER -- requirements
Module: bus_msg_transmitter

Interface
REQ-001 SHALL have parameter: width, 32, beat width in bits; only 32 is supported.
REQ-002 SHALL have port: CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: in$enq__ENA  input  1  message enqueue; asserted only while in$enq__RDY=1.
REQ-005 SHALL have port: in$enq$v  input  144  message; [15:0] header, [143:16] payload words 0..3, word 0 in LSBs.
REQ-006 SHALL have port: in$enq__RDY  output  1  block can accept a message this cycle.
REQ-007 SHALL have port: out$enq__ENA  output  1  beat transfer; asserted only while out$enq__RDY=1.
REQ-008 SHALL have port: out$enq$v  output  width  beat data.
REQ-009 SHALL have port: out$enq$last  output  1  final beat of the current message.
REQ-010 SHALL have port: out$enq__RDY  input  1  downstream can take a beat.
REQ-011 SHALL have port: len_err  output  1  sticky flag, header length field out of range.

Function
REQ-012 SHALL implement states IDLE, HDR, PAY; a message is captured into a 144-bit holding register on in$enq__ENA.
REQ-013 SHALL derive beat count N from header[2:0]: values 0..4 used as-is; values 5..7 clamped to N=4 and set len_err.
REQ-014 SHALL drive in$enq__RDY=1 only in IDLE (skid exception in REQ-025).
REQ-015 SHALL go IDLE->HDR in the cycle after acceptance, so the header beat is offered one cycle after in$enq__ENA.
REQ-016 SHALL drive the header beat as {16'h0000, header}, with out$enq$last=1 iff N=0.
REQ-017 SHALL drive out$enq__ENA = (state is HDR or PAY) AND out$enq__RDY; a beat completes only on a cycle where out$enq__ENA=1.
REQ-018 SHALL go HDR->PAY on header transfer when N>0, or HDR->IDLE when N=0.
REQ-019 SHALL emit payload word k (k=0..N-1) as in$enq$v[16+32k +: 32] in increasing k, using a 3-bit beat counter.
REQ-020 SHALL assert out$enq$last on payload beat k=N-1 only and return to IDLE on its transfer.
REQ-021 SHALL hold out$enq$v and out$enq$last stable while out$enq__RDY=0; stalls of any length SHALL lose no beat.
REQ-022 SHALL drive out$enq$v=0 and out$enq$last=0 in IDLE.
REQ-023 SHALL clear len_err only on RST; it SHALL NOT affect beat sequencing.

Reset
REQ-024 SHALL, on RST=1 at a clock edge, enter IDLE, clear beat counter, holding register and len_err, and drive in$enq__RDY=1 and out$enq__ENA=0 from the next cycle; an in-flight message is abandoned with no last beat emitted.

Configuration
REQ-025 SHALL support macro BUS_MSG_TX_SKID_EN: when defined, in$enq__RDY is also 1 during the cycle the last beat transfers, so a new message is captured that cycle and its header is offered the next cycle (no bubble); when undefined, at least one IDLE cycle separates messages.

Verification
REQ-026 SHALL cover: header 16'h0003, payload words 11111111/22222222/33333333, out$enq__RDY=1 -> beats 00000003, 11111111, 22222222, 33333333; last only on 4th; header beat at cycle +1.
REQ-027 SHALL cover: header 16'h0000 -> single beat 00000000 with last=1; state returns to IDLE.
REQ-028 SHALL cover: header 16'h0007 -> 5 beats (header + 4 words), len_err=1 and stays 1 across later good messages until RST.
REQ-029 SHALL cover: N=2 with out$enq__RDY low for 5 cycles after header -> data and last held stable; exactly 3 beats delivered.
REQ-030 SHALL cover: RST pulsed during payload beat 1 of N=4 -> no further beats; in$enq__RDY=1 next cycle; next message sent complete.
REQ-031 SHALL cover: two back-to-back N=1 messages -> with BUS_MSG_TX_SKID_EN 4 beats in 4 consecutive cycles; without it, one idle cycle between messages.

Source files
------------

// File: rtl/bus_msg_transmitter.sv
// Serialises a 144-bit header+payload message into 32-bit beats: header beat, then N payload words.
// Optional macro BUS_MSG_TX_SKID_EN lets a new message be accepted in the cycle the last beat transfers.
module bus_msg_transmitter #(
    parameter int unsigned width = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_enq__ENA,
    input  logic [143:0]     in_enq_v,
    output logic             in_enq__RDY,
    output logic             out_enq__ENA,
    output logic [width-1:0] out_enq_v,
    output logic             out_enq_last,
    input  logic             out_enq__RDY,
    output logic             len_err
);

    typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

    state_t           state, state_next;
    logic [143:0]     hold;
    logic [2:0]       beats;
    logic [2:0]       cnt;
    logic [width-1:0] word;
    logic [2:0]       hdr_len;
    logic             len_bad;
    logic             accept;

    assign hdr_len = in_enq_v[2:0];
    assign len_bad = (hdr_len > 3'd4);
    assign accept  = in_enq__RDY && in_enq__ENA;

    always_comb begin
        word = '0;
        case (cnt[1:0])
            2'd0: word = hold[16  +: width];
            2'd1: word = hold[48  +: width];
            2'd2: word = hold[80  +: width];
            2'd3: word = hold[112 +: width];
            default: word = '0;
        endcase
    end

    always_comb begin
        state_next   = state;
        in_enq__RDY  = 1'b0;
        out_enq__ENA = 1'b0;
        out_enq_v    = '0;
        out_enq_last = 1'b0;
        case (state)
            IDLE: begin
                in_enq__RDY = 1'b1;
                if (in_enq__ENA) state_next = HDR;
            end
            HDR: begin
                out_enq_v    = {{(width-16){1'b0}}, hold[15:0]};
                out_enq_last = (beats == 3'd0);
                out_enq__ENA = out_enq__RDY;
                if (out_enq__ENA) state_next = out_enq_last ? IDLE : PAY;
            end
            PAY: begin
                out_enq_v    = word;
                out_enq_last = (cnt == beats - 3'd1);
                out_enq__ENA = out_enq__RDY;
                if (out_enq__ENA && out_enq_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
`ifdef BUS_MSG_TX_SKID_EN
        // Overlap: the final beat's transfer cycle doubles as the next acceptance cycle.
        if (out_enq__ENA && out_enq_last) begin
            in_enq__RDY = 1'b1;
            if (in_enq__ENA) state_next = HDR;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            hold    <= '0;
            beats   <= '0;
            cnt     <= '0;
            len_err <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                hold  <= in_enq_v;
                beats <= len_bad ? 3'd4 : hdr_len;
                cnt   <= '0;
                if (len_bad) len_err <= 1'b1;
            end else if (state == PAY && out_enq__ENA) begin
                cnt <= cnt + 3'd1;
            end
        end
    end

endmodule
